mc_sequencer: RTL

Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle combinational control path with a Moore FSM that steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It drives the PC, IR, memory and register-file write enables around the existing PC, inst_mem, inst_decode, reg_file and ALU blocks. It also handles variable-latency memories through a request/ready handshake and counts retired instructions.

---
 rtl/rv_pkg.sv | 54 +++++
 rtl/mc_wait_timer.sv | 32 +++
 rtl/mc_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, sequencer
// states, instruction classes and writeback-source selects.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_SYSTEM  = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // R, I-ALU and LUI share one path: EXEC then WB from the ALU result.
    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            OP_R, OP_I, OP_LUI: c = CLS_ALU;
            OP_LOAD:            c = CLS_LOAD;
            OP_STORE:           c = CLS_STORE;
            OP_BRANCH:          c = CLS_BRANCH;
            OP_JAL:             c = CLS_JAL;
            OP_SYSTEM:          c = CLS_SYSTEM;
            default:            c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Per-state wait counter for memory handshakes: clears on state entry,
// counts non-ready cycles, saturates at 8 bits and flags the last allowed wait.
module mc_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(LIMIT - 1);

    logic [7:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // High during the LIMIT-th consecutive non-ready cycle of the current state.
    assign expired = (cnt >= LAST_WAIT);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle Moore control sequencer for the RV32I core: steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module mc_sequencer
    import rv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_en,
    output logic             pc_sel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    state_t           cur, nxt;
    cls_t             cls_q, cls_d;
    logic             ill_q, to_q, set_ill, set_to;
    logic [CNT_W-1:0] ret_q;
    logic             wait_clr, wait_inc, wait_expired;

    assign wait_clr = (nxt != cur);
    assign wait_inc = (cur == FETCH && !imem_rdy) || (cur == MEM && !dmem_rdy);

    mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wait_clr),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        nxt      = cur;
        cls_d    = cls_q;
        set_ill  = 1'b0;
        set_to   = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        pc_en    = 1'b0;
        pc_sel   = 1'b0;

        unique case (cur)
            IDLE: nxt = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end else if (wait_expired) begin
                    set_to = 1'b1;
                    nxt    = HALT;
                end
            end

            DECODE: begin
                cls_d = classify(opcode);
                case (cls_d)
                    CLS_SYSTEM:  nxt = HALT;
                    CLS_ILLEGAL: begin
                        set_ill = 1'b1;
                        nxt     = HALT;
                    end
                    default:     nxt = EXEC;
                endcase
            end

            EXEC: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: nxt = MEM;
                    CLS_BRANCH: begin
                        pc_en  = 1'b1;
                        pc_sel = br_taken;
                        nxt    = FETCH;
                    end
                    default: nxt = WB;
                endcase
            end

            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_rdy) begin
                    if (cls_q == CLS_STORE) begin
                        pc_en = 1'b1;
                        nxt   = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end else if (wait_expired) begin
                    set_to = 1'b1;
                    nxt    = HALT;
                end
            end

            WB: begin
                reg_we = 1'b1;
                pc_en  = 1'b1;
                pc_sel = (cls_q == CLS_JAL);
                if (cls_q == CLS_LOAD)     wb_sel = WB_MEM;
                else if (cls_q == CLS_JAL) wb_sel = WB_PC4;
                nxt = FETCH;
            end

            HALT: nxt = HALT;

            default: nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= IDLE;
            cls_q <= CLS_NONE;
            ill_q <= 1'b0;
            to_q  <= 1'b0;
            ret_q <= '0;
        end else begin
            cur   <= nxt;
            cls_q <= cls_d;
            if (set_ill) ill_q <= 1'b1;
            if (set_to)  to_q  <= 1'b1;
            // Every retirement point coincides with the single PC update.
            if (pc_en)   ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign state   = cur;
    assign illegal = ill_q;
    assign timeout = to_q;
    assign retired = ret_q;

endmodule
